video_page_writer: RTL

- Write-side engine for the 4-page 320x200 framebuffer. The display scanout reads these pages; this block writes them.
- Executes the CPU's fillVideoPage and copyVideoPage video instructions, including copy with vertical scroll, into the shared page RAM.
- Runs at one pixel per clock, using a valid/ready command handshake from the VM CPU.

---
 rtl/video_pkg.sv | 28 ++
 rtl/page_addr_gen.sv | 20 ++
 rtl/video_page_writer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared framebuffer constants, command encodings and writer state type.
// Optional PLOT support is enabled with VIDEO_PAGE_WRITER_PLOT_EN.
package video_pkg;

  localparam int WIDTH     = 320;
  localparam int HEIGHT    = 200;
  localparam int NUM_PAGES = 4;
  localparam int PIX_W     = 4;
  localparam int ADDR_W    = 18;
  localparam int PAGE_SIZE = WIDTH * HEIGHT;

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_PLOT = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COPY,
    ST_DRAIN,
    ST_DONE
`ifdef VIDEO_PAGE_WRITER_PLOT_EN
    , ST_PLOT
`endif
  } wr_state_t;

endpackage

// File: rtl/page_addr_gen.sv
// Maps (page, row, column) to a linear page RAM address.
// Only used for command start addresses, so constant multiplies are fine here.
module page_addr_gen #(
  parameter int WIDTH  = video_pkg::WIDTH,
  parameter int HEIGHT = video_pkg::HEIGHT,
  parameter int PAGE_W = 2,
  parameter int ADDR_W = video_pkg::ADDR_W
) (
  input  logic [PAGE_W-1:0] page,
  input  logic [7:0]        y,
  input  logic [8:0]        x,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] PAGE_SZ = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_SZ  = ADDR_W'(WIDTH);

  assign addr = ADDR_W'(page) * PAGE_SZ + ADDR_W'(y) * ROW_SZ + ADDR_W'(x);

endmodule

// File: rtl/video_page_writer.sv
// Framebuffer write engine: FILL, COPY with vertical scroll, optional PLOT.
// PLOT is built only when VIDEO_PAGE_WRITER_PLOT_EN is defined.
module video_page_writer #(
  parameter int WIDTH     = video_pkg::WIDTH,
  parameter int HEIGHT    = video_pkg::HEIGHT,
  parameter int NUM_PAGES = video_pkg::NUM_PAGES,
  parameter int PIX_W     = video_pkg::PIX_W,
  parameter int ADDR_W    = video_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(NUM_PAGES)-1:0] cmd_page_a,
  input  logic [$clog2(NUM_PAGES)-1:0] cmd_page_b,
  input  logic [PIX_W-1:0]             cmd_color,
  input  logic [8:0]                   cmd_vscroll,
  input  logic [8:0]                   cmd_x,
  input  logic [7:0]                   cmd_y,
  output logic [ADDR_W-1:0]            mem_raddr,
  input  logic [PIX_W-1:0]             mem_rdata,
  output logic [ADDR_W-1:0]            mem_waddr,
  output logic [PIX_W-1:0]             mem_wdata,
  output logic                         mem_we,
  output logic                         busy,
  output logic                         done
);
  import video_pkg::*;

  localparam int PAGE_W = $clog2(NUM_PAGES);

  wr_state_t           state;
  logic [ADDR_W-1:0]   raddr_q, waddr_q, pix_left;
  logic [ADDR_W:0]     delta_q;
  logic [PIX_W-1:0]    wdata_q;
  logic                we_q, done_q, busy_q, ready_q, wsel_rd, row_desc;
  logic [8:0]          col_left;
  logic [7:0]          rows_left;

  logic [8:0]          vs_abs, copy_rows, gen_x;
  logic [7:0]          src_y0, dst_y0, gen_y;
  logic                scroll_down, accept;
  logic [ADDR_W-1:0]   src_addr, dst_addr;
`ifdef VIDEO_PAGE_WRITER_PLOT_EN
  logic                plot_in_range;
`endif

  // Source/destination start rows: scrolling down walks rows bottom-up so
  // a same-page copy never reads a row it already overwrote.
  always_comb begin
    vs_abs      = cmd_vscroll[8] ? (~cmd_vscroll + 9'd1) : cmd_vscroll;
    scroll_down = !cmd_vscroll[8] && (cmd_vscroll != 9'd0);
    copy_rows   = (vs_abs >= 9'(HEIGHT)) ? 9'd0 : 9'(HEIGHT) - vs_abs;
    src_y0      = scroll_down ? 8'(9'(HEIGHT - 1) - vs_abs) : vs_abs[7:0];
    dst_y0      = scroll_down ? 8'(HEIGHT - 1) : 8'd0;
    gen_y       = 8'd0;
    gen_x       = 9'd0;
    if (cmd_op == OP_COPY) begin
      gen_y = src_y0;
    end else if (cmd_op == OP_PLOT) begin
      gen_y = cmd_y;
      gen_x = cmd_x;
    end
  end

`ifdef VIDEO_PAGE_WRITER_PLOT_EN
  assign plot_in_range = (cmd_x < 9'(WIDTH)) && ({1'b0, cmd_y} < 9'(HEIGHT));
`endif

  assign accept = cmd_valid && ready_q;

  page_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PAGE_W(PAGE_W), .ADDR_W(ADDR_W)) u_src_addr (
    .page (cmd_page_a),
    .y    (gen_y),
    .x    (gen_x),
    .addr (src_addr)
  );

  page_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PAGE_W(PAGE_W), .ADDR_W(ADDR_W)) u_dst_addr (
    .page (cmd_page_b),
    .y    (dst_y0),
    .x    (9'd0),
    .addr (dst_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      raddr_q   <= '0;
      waddr_q   <= '0;
      pix_left  <= '0;
      delta_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      wsel_rd   <= 1'b0;
      row_desc  <= 1'b0;
      col_left  <= '0;
      rows_left <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          we_q    <= 1'b0;
          wsel_rd <= 1'b0;
          if (accept) begin
            case (cmd_op)
              OP_FILL: begin
                state    <= ST_FILL;
                we_q     <= 1'b1;
                waddr_q  <= src_addr;
                wdata_q  <= cmd_color;
                pix_left <= ADDR_W'(WIDTH * HEIGHT - 1);
                busy_q   <= 1'b1;
                ready_q  <= 1'b0;
              end
              OP_COPY: begin
                if (copy_rows == 9'd0) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                end else begin
                  state     <= ST_COPY;
                  raddr_q   <= src_addr;
                  delta_q   <= {1'b0, dst_addr} - {1'b0, src_addr};
                  col_left  <= 9'(WIDTH - 1);
                  rows_left <= 8'(copy_rows - 9'd1);
                  row_desc  <= scroll_down;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
                end
              end
`ifdef VIDEO_PAGE_WRITER_PLOT_EN
              OP_PLOT: begin
                state   <= ST_PLOT;
                we_q    <= plot_in_range;
                waddr_q <= src_addr;
                wdata_q <= cmd_color;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
              end
`endif
              default: begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        ST_FILL: begin
          if (pix_left == '0) begin
            state   <= ST_DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            waddr_q  <= waddr_q + 1'b1;
            pix_left <= pix_left - 1'b1;
          end
        end
        ST_COPY: begin
          // The write lands one cycle after its read, when mem_rdata is valid.
          we_q    <= 1'b1;
          wsel_rd <= 1'b1;
          waddr_q <= ADDR_W'({1'b0, raddr_q} + delta_q);
          if (col_left == 9'd0) begin
            if (rows_left == 8'd0) begin
              state <= ST_DRAIN;
            end else begin
              col_left  <= 9'(WIDTH - 1);
              rows_left <= rows_left - 1'b1;
              raddr_q   <= row_desc ? raddr_q - ADDR_W'(2 * WIDTH - 1) : raddr_q + 1'b1;
            end
          end else begin
            col_left <= col_left - 1'b1;
            raddr_q  <= raddr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state   <= ST_DONE;
          we_q    <= 1'b0;
          wsel_rd <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
`ifdef VIDEO_PAGE_WRITER_PLOT_EN
        ST_PLOT: begin
          state   <= ST_DONE;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wsel_rd ? mem_rdata : wdata_q;

endmodule
